serial_addsub_lanes: RTL

Multi-lane bit-serial adder/subtractor. Operands arrive LSB-first, one bit per lane per accepted cycle, framed into WIDTH-bit words by a start pulse. Per-lane carry is held in a register across bits. It is the parametrised successor of the team's single-lane serial adder: it adds subtract mode, a valid/stall qualifier, word framing, per-lane carry-out and signed-overflow flags. It sits between the serialiser front-end and the serial accumulator datapath.

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/serial_fa_lane.sv | 63 ++++++
 rtl/serial_addsub_lanes.sv | 97 +++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types for the multi-lane bit-serial adder/subtractor.
package serial_addsub_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_LANES = 4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Broadcast from the framing FSM to every lane cell.
  typedef struct packed {
    logic accept;   // a bit is consumed this cycle
    logic first;    // bit 0 of a word: carry-in comes from sub_eff
    logic msb;      // last bit of an uninterrupted word: latch flags
    logic sub_eff;  // effective subtract mode for this bit
  } lane_ctl_t;
endpackage

// File: rtl/serial_fa_lane.sv
// One serial full-adder lane: carry register, registered sum and MSB flags.
module serial_fa_lane
  import serial_addsub_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  input  lane_ctl_t ctl,
  input  logic      x,
  input  logic      y,
  output logic      sum,
  output logic      carry_out,
  output logic      overflow
);
  logic carry_q, carry_d;
  logic sum_q, sum_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;
  logic yy, cin, s_nxt, c_nxt;

  always_comb begin
    yy      = y ^ ctl.sub_eff;
    cin     = ctl.first ? ctl.sub_eff : carry_q;
    s_nxt   = x ^ yy ^ cin;
    c_nxt   = (x & yy) | (cin & (x ^ yy));
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (ctl.accept) begin
      sum_d   = s_nxt;
      carry_d = c_nxt;
      // Signed overflow: carry into the MSB differs from carry out of it.
      if (ctl.msb) begin
        cout_d = c_nxt;
        ovf_d  = cin ^ c_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      sum_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      carry_q <= 1'b0;
      sum_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
endmodule

// File: rtl/serial_addsub_lanes.sv
// LANES bit-serial add/sub lanes sharing one word-framing FSM; LSB first.
module serial_addsub_lanes
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LANES = DEFAULT_LANES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             start,
  input  logic             sub,
  input  logic [LANES-1:0] x,
  input  logic [LANES-1:0] y,
  output logic [LANES-1:0] sum,
  output logic             out_valid,
  output logic             out_last,
  output logic [LANES-1:0] carry_out,
  output logic [LANES-1:0] overflow
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sub_q, sub_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             new_word;
  lane_ctl_t        ctl;

  always_comb begin
    new_word    = in_valid & start;
    ctl.accept  = in_valid & ((state_q == RUN) | start);
    ctl.first   = new_word;
    // A start on the MSB cycle aborts the word, so it never raises msb.
    ctl.msb     = ctl.accept & ~start & (state_q == RUN) & (bit_cnt_q == LAST_BIT);
    ctl.sub_eff = new_word ? sub : sub_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sub_d       = sub_q;
    out_valid_d = ctl.accept;
    out_last_d  = ctl.msb;
    if (new_word) begin
      state_d   = RUN;
      bit_cnt_d = CNT_W'(1);
      sub_d     = sub;
    end else if (ctl.accept) begin
      if (ctl.msb) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    serial_fa_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .ctl       (ctl),
      .x         (x[l]),
      .y         (y[l]),
      .sum       (sum[l]),
      .carry_out (carry_out[l]),
      .overflow  (overflow[l])
    );
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
endmodule
